// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer slow-time base and its countdown channels.
package tick_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int TICK_CYCLES_DE10 = 33_000_000;
    localparam int TICK_CYCLES_SIM  = 20;

    // Width needed to hold prescaler values 0 .. cycles-1 (never narrower than 1 bit).
    function automatic int prescaler_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/tick_timer_channel.sv
// One restartable countdown channel: IDLE/RUN FSM plus count register, stepped by the shared tick.
module tick_timer_channel
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick_int,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    // cancel beats start beats tick; a start in the tick cycle swallows that tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = 1'b0;
        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            if (load_val == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
                exp_d   = 1'b1;
            end else begin
                state_d = RUN;
                cnt_d   = load_val;
            end
        end else if (tick_int && (state_q == RUN)) begin
            if (cnt_q != CNT_W'(1)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                exp_d   = 1'b1;
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign expired   = exp_q;
    assign remaining = cnt_q;

endmodule

// File: rtl/tick_timer.sv
// Game time base: pausable prescaler with turbo rate, free-running tick counter and NUM_CH countdown channels.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DE10,
    parameter int TURBO_DIV   = 10,
    parameter int CNT_W       = 8,
    parameter int NUM_CH      = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    turbo,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    output logic                    tick,
    output logic [CNT_W-1:0]        tick_count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam int PW      = prescaler_width(TICK_CYCLES);
    localparam int P_TURBO = TICK_CYCLES / TURBO_DIV;

    logic [PW-1:0] pcnt;
    logic [PW-1:0] period_m1;
    logic          tick_int;

    // Using >= lets a switch into turbo with pcnt already past the short period tick at once.
    assign period_m1 = turbo ? PW'(P_TURBO - 1) : PW'(TICK_CYCLES - 1);
    assign tick_int  = !pause && (pcnt >= period_m1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pcnt       <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            tick <= tick_int;
            if (tick_int) begin
                pcnt       <= '0;
                tick_count <= tick_count + CNT_W'(1);
            end else if (!pause) begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        tick_timer_channel #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk      (clk),
            .resetN   (resetN),
            .tick_int (tick_int),
            .start    (start[c]),
            .cancel   (cancel[c]),
            .load_val (load_val[c*CNT_W +: CNT_W]),
            .busy     (busy[c]),
            .expired  (expired[c]),
            .remaining(remaining[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_tick_timer;

    localparam int TICK_CYCLES = 20;
    localparam int TURBO_DIV   = 10;
    localparam int CNT_W       = 8;
    localparam int NUM_CH      = 4;

    logic                    clk = 1'b0;
    logic                    resetN;
    logic                    turbo;
    logic                    pause;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       cancel;
    logic [NUM_CH*CNT_W-1:0] load_val;
    logic                    tick;
    logic [CNT_W-1:0]        tick_count;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH*CNT_W-1:0] remaining;

    int test_count = 0;
    int fail_count = 0;

    // Behavioural model state
    int m_phase;
    bit m_tick;
    int m_count;
    int m_rem [NUM_CH];
    bit m_busy[NUM_CH];
    bit m_exp [NUM_CH];

    tick_timer #(
        .TICK_CYCLES(TICK_CYCLES),
        .TURBO_DIV  (TURBO_DIV),
        .CNT_W      (CNT_W),
        .NUM_CH     (NUM_CH)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .turbo     (turbo),
        .pause     (pause),
        .start     (start),
        .cancel    (cancel),
        .load_val  (load_val),
        .tick      (tick),
        .tick_count(tick_count),
        .busy      (busy),
        .expired   (expired),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_phase = 0;
        m_tick  = 0;
        m_count = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_rem[c]  = 0;
            m_busy[c] = 0;
            m_exp[c]  = 0;
        end
    endtask

    function automatic int activePeriod();
        return turbo ? TICK_CYCLES / TURBO_DIV : TICK_CYCLES;
    endfunction

    function automatic bit modelFiresNext();
        return !pause && (m_phase + 1 >= activePeriod());
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        bit fire;
        int v;
        if (!resetN) begin
            modelReset();
            return;
        end
        fire = modelFiresNext();
        if (fire) m_phase = 0;
        else if (!pause) m_phase++;
        m_tick = fire;
        if (fire) m_count = (m_count + 1) % (1 << CNT_W);
        for (int c = 0; c < NUM_CH; c++) begin
            v = int'(load_val[c*CNT_W +: CNT_W]);
            m_exp[c] = 0;
            if (cancel[c]) begin
                m_rem[c] = 0;  m_busy[c] = 0;
            end else if (start[c]) begin
                m_rem[c]  = v;
                m_busy[c] = (v != 0);
                m_exp[c]  = (v == 0);
            end else if (fire && m_busy[c]) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_busy[c] = 0;  m_exp[c] = 1;
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NUM_CH-1:0]       e_busy, e_exp;
        logic [NUM_CH*CNT_W-1:0] e_rem;
        for (int c = 0; c < NUM_CH; c++) begin
            e_busy[c] = m_busy[c];
            e_exp[c]  = m_exp[c];
            e_rem[c*CNT_W +: CNT_W] = CNT_W'(m_rem[c]);
        end
        checkOutput({tag, ".tick"},       64'(tick),       64'(m_tick));
        checkOutput({tag, ".tick_count"}, 64'(tick_count), 64'(m_count));
        checkOutput({tag, ".busy"},       64'(busy),       64'(e_busy));
        checkOutput({tag, ".expired"},    64'(expired),    64'(e_exp));
        checkOutput({tag, ".remaining"},  64'(remaining),  64'(e_rem));
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic clearStrobes();
        start  = '0;
        cancel = '0;
    endtask

    task automatic setLoad(input int c, input int v);
        load_val[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(63) == 0) turbo = ~turbo;
            pause = ($urandom_range(15) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                start[c]  = ($urandom_range(11) == 0);
                cancel[c] = ($urandom_range(39) == 0);
                setLoad(c, ($urandom_range(3) == 0) ? 0 : int'($urandom_range(6, 1)));
            end
            stepCycle("rand");
        end
        clearStrobes();
        pause = 1'b0;
    endtask

    initial begin
        bit found;
        int ticks_seen;

        resetN   = 1'b0;
        turbo    = 1'b0;
        pause    = 1'b0;
        start    = '0;
        cancel   = '0;
        load_val = '0;
        modelReset();
        #1;
        checkAll("reset");
        repeat (3) stepCycle("in_reset");
        resetN = 1'b1;

        // Free run: ticks at edges 20, 40, 60 after release
        for (int i = 1; i <= 60; i++) begin
            stepCycle("free");
            if (i == 20 || i == 40 || i == 60) checkOutput("tick_at_period", 64'(tick), 64'd1);
        end
        checkOutput("tick_count_after_60", 64'(tick_count), 64'd3);

        // Turbo asserted at pcnt = 7
        repeat (7) stepCycle("pre_turbo");
        turbo = 1'b1;
        stepCycle("turbo");
        checkOutput("turbo_first_tick", 64'(tick), 64'd1);
        stepCycle("turbo");
        checkOutput("turbo_gap", 64'(tick), 64'd0);
        stepCycle("turbo");
        checkOutput("turbo_second_tick", 64'(tick), 64'd1);
        repeat (6) stepCycle("turbo");
        turbo = 1'b0;
        repeat (45) stepCycle("normal");

        // Channel 0 countdown from 3
        start[0] = 1'b1;
        setLoad(0, 3);
        stepCycle("ch0_load");
        clearStrobes();
        checkOutput("ch0_busy", 64'(busy[0]), 64'd1);
        checkOutput("ch0_rem", 64'(remaining[CNT_W-1:0]), 64'd3);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            stepCycle("ch0_run");
            if (expired[0]) begin
                found = 1;
                checkOutput("ch0_exp_with_tick", 64'(tick), 64'd1);
                checkOutput("ch0_busy_drop", 64'(busy[0]), 64'd0);
            end
        end
        checkOutput("ch0_expired_seen", 64'(found), 64'd1);

        // start[1] coincident with tick reloads without decrement
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (modelFiresNext()) found = 1;
            else stepCycle("wait_tick");
        end
        checkOutput("tick_found", 64'(found), 64'd1);
        start[1] = 1'b1;
        setLoad(1, 5);
        stepCycle("prio_tick");
        clearStrobes();
        checkOutput("start_over_tick", 64'(remaining[CNT_W +: CNT_W]), 64'd5);

        // start + cancel on channel 2
        start[2]  = 1'b1;
        cancel[2] = 1'b1;
        setLoad(2, 7);
        stepCycle("prio_cancel");
        clearStrobes();
        checkOutput("cancel_busy", 64'(busy[2]), 64'd0);
        checkOutput("cancel_noexp", 64'(expired[2]), 64'd0);

        // load 0 expires one cycle later
        start[3] = 1'b1;
        setLoad(3, 0);
        stepCycle("load_zero");
        clearStrobes();
        checkOutput("zero_expired", 64'(expired[3]), 64'd1);
        stepCycle("load_zero_after");
        checkOutput("zero_expired_once", 64'(expired[3]), 64'd0);

        // Pause mid-countdown
        start[0] = 1'b1;
        setLoad(0, 4);
        stepCycle("pause_load");
        clearStrobes();
        repeat (27) stepCycle("pre_pause");
        pause = 1'b1;
        repeat (50) stepCycle("paused");
        checkOutput("pause_rem_frozen", 64'(remaining[CNT_W-1:0]), 64'(m_rem[0]));
        pause = 1'b0;
        repeat (60) stepCycle("post_pause");

        // Randomized traffic
        applyStimulus(3000);
        turbo = 1'b0;

        // Async reset mid-countdown on all channels
        for (int c = 0; c < NUM_CH; c++) begin
            start[c] = 1'b1;
            setLoad(c, 5 + c);
        end
        stepCycle("all_load");
        clearStrobes();
        repeat (25) stepCycle("all_run");
        #2;
        resetN = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        checkOutput("async_busy_zero", 64'(busy), 64'd0);
        stepCycle("held_reset");
        resetN = 1'b1;

        // Wrap: 256 ticks return tick_count to 0
        turbo = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 2000 && ticks_seen < 256; i++) begin
            stepCycle("wrap");
            if (m_tick) ticks_seen++;
        end
        checkOutput("wrap_ticks_reached", 64'(ticks_seen), 64'd256);
        checkOutput("wrap_count_zero", 64'(tick_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
# tick_timer

Parametrised slow-time base plus multi-channel countdown timers for game timing (bomb fuses, explosion duration, power-up expiry). A shared prescaler divides the system clock into a one-cycle `tick` with selectable turbo rate and pause. A free-running tick counter and NUM_CH independent, restartable countdown channels run from that tick; each channel pulses `expired` when its count reaches zero. The block sits between game-control logic and the object/bomb FSMs that consume tick and expiry events.

## Interface
- TICK_CYCLES, 33_000_000 — clock cycles per normal tick (use 20 for simulation); must be ≥ 2·TURBO_DIV
- TURBO_DIV, 10 — turbo speed-up factor; turbo period = TICK_CYCLES/TURBO_DIV, integer division at elaboration
- CNT_W, 8 — width of the tick counter and of each channel's count
- NUM_CH, 4 — number of countdown channels, ≥ 1
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- turbo  in  1  1 = use turbo period
- pause  in  1  1 = freeze prescaler; no ticks
- start  in  NUM_CH  per-channel load/start strobe
- cancel  in  NUM_CH  per-channel abort strobe
- load_val  in  NUM_CH·CNT_W  channel c value at bits [c·CNT_W +: CNT_W]
- tick  out  1  one-cycle pulse per period
- tick_count  out  CNT_W  ticks since reset, wraps 2^CNT_W−1 → 0
- busy  out  NUM_CH  channel in RUN
- expired  out  NUM_CH  one-cycle pulse at countdown end
- remaining  out  NUM_CH·CNT_W  current channel counts, same packing as load_val

## Operation
- Prescaler `pcnt`, width ceil(log2(TICK_CYCLES)). Active period P = turbo ? TICK_CYCLES/TURBO_DIV : TICK_CYCLES.
- Internal `tick_int` = !pause && (pcnt ≥ P−1). On edge: tick_int → pcnt ← 0; pause → pcnt holds; else pcnt+1.
- `≥` handles turbo asserted while pcnt exceeds the new P−1: tick on the next edge, then the normal cadence.
- `tick` and `tick_count` are registered from tick_int. tick_count increments modulo 2^CNT_W.
- Channel FSM, states IDLE and RUN. Priority per channel per edge: cancel > start > tick.
  - cancel: → IDLE, remaining ← 0, no expired pulse. Legal in any state.
  - start, load_val = 0: stays or goes IDLE, remaining ← 0, expired pulses.
  - start, load_val = N > 0: → RUN, remaining ← N. Restart while RUN reloads, and the coincident tick is ignored.
  - tick_int in RUN, remaining > 1: remaining − 1.
  - tick_int in RUN, remaining = 1: remaining ← 0, → IDLE, expired pulses.
  - pause freezes all RUN channels, since tick_int is 0.
- busy = (state == RUN).
- expired is registered: high for exactly one cycle, never for two consecutive cycles without a new start.

## Timing
- Reset values: pcnt = 0, tick = 0, tick_count = 0, all channels IDLE, busy = 0, expired = 0, remaining = 0.
- Reset is asynchronous: an assertion mid-count aborts all channels with no expired pulse.
- With pause = 0 and turbo constant, tick first rises P edges after reset release, then every P cycles.
- Channel loaded with N at edge e0, pause = 0: expired rises on the same edge as the N-th tick after e0, in the same cycle as tick.
- remaining updates on the same edge as tick.
- start at edge e with load_val = 0: expired is high in the cycle after e.
- All outputs are registered. No combinational input-to-output paths.

## Structure
- Package `tick_timer_pkg` holds:
  - `chan_state_t` enum {IDLE, RUN}
  - localparams TICK_CYCLES_DE10 = 33_000_000 and TICK_CYCLES_SIM = 20
  - a function computing prescaler width
- Sub-module `tick_timer_channel`: one FSM plus count register, with inputs tick_int, start, cancel, load_val. Instantiated NUM_CH times in a generate loop.
- Top level holds the prescaler, tick register, tick_count and channel packing.

## Test plan
Parameters: TICK_CYCLES=20, TURBO_DIV=10, CNT_W=8, NUM_CH=4.
- Reset then free run: tick pulses at edges 20, 40, 60; tick_count = 3 after edge 60; all other outputs 0.
- Turbo: assert turbo at pcnt = 7 → tick on the next edge, then every 2 cycles. Deassert → every 20 cycles.
- Channel 0 loaded with 3: busy = 1; remaining steps 3, 2, 1, 0 on successive ticks; expired[0] and tick are high in the same cycle; busy drops to 0.
- Priorities:
  - start[1] (load 5) coincident with tick → remaining = 5, not 4.
  - start + cancel on channel 2 → IDLE, no expired.
  - load_val 0 → expired one cycle later.
- Pause for 50 cycles mid-countdown: no ticks, remaining frozen, pcnt holds. On release, the next tick comes after the remaining cycles of the interrupted period.
- Async reset mid-countdown on all channels: outputs go 0 immediately with no expired pulse. Wrap: 256 ticks → tick_count returns to 0.
